// File: rtl/seq_checker_if.sv
// Bus between a counter data path and seq_checker: sampled word, valid, clear, and status.
// Optional ERR_STICKY member exists only when SEQ_CHECK_STICKY_EN is defined.
interface seq_checker_if #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned ERR_CNT_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     in_valid;
    logic                     clr_cnt;
    logic                     locked;
    logic                     error;
    logic [ERR_CNT_WIDTH-1:0] err_count;
`ifdef SEQ_CHECK_STICKY_EN
    logic                     err_sticky;

    modport master (
        output data_in, in_valid, clr_cnt,
        input  locked, error, err_count, err_sticky
    );

    modport slave (
        input  data_in, in_valid, clr_cnt,
        output locked, error, err_count, err_sticky
    );
`else
    modport master (
        output data_in, in_valid, clr_cnt,
        input  locked, error, err_count
    );

    modport slave (
        input  data_in, in_valid, clr_cnt,
        output locked, error, err_count
    );
`endif
endinterface

// File: rtl/seq_checker.sv
// Incrementing-sequence checker: locks onto a +1 stream, flags and counts mismatches.
// Optional sticky error flag enabled by defining SEQ_CHECK_STICKY_EN.
module seq_checker #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned LOCK_COUNT    = 3,
    parameter int unsigned UNLOCK_ERRORS = 2,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    seq_checker_if.slave bus
);
    localparam int unsigned GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam int unsigned ERR_RUN_W = $clog2(UNLOCK_ERRORS + 1);

    localparam logic [GOOD_W-1:0]        GOOD_LOCK  = GOOD_W'(LOCK_COUNT);
    localparam logic [ERR_RUN_W-1:0]     ERR_UNLOCK = ERR_RUN_W'(UNLOCK_ERRORS);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE    = ERR_CNT_WIDTH'(1);

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    prev_q, prev_d;
    logic [DATA_WIDTH-1:0]    expected_q, expected_d;
    logic                     hist_valid_q, hist_valid_d;
    logic [GOOD_W-1:0]        good_run_q, good_run_d;
    logic [ERR_RUN_W-1:0]     err_run_q, err_run_d;
    logic                     error_q, error_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic [DATA_WIDTH-1:0]    prev_inc;
    logic [DATA_WIDTH-1:0]    sample_inc;
    logic [GOOD_W-1:0]        good_inc;
    logic [ERR_RUN_W-1:0]     err_inc;
    logic                     mismatch;

    // Width-truncated increments so all-ones wraps to zero.
    assign prev_inc   = prev_q + 1'b1;
    assign sample_inc = bus.data_in + 1'b1;
    assign good_inc   = good_run_q + 1'b1;
    assign err_inc    = err_run_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        expected_d   = expected_q;
        hist_valid_d = hist_valid_q;
        good_run_d   = good_run_q;
        err_run_d    = err_run_q;
        error_d      = 1'b0;
        mismatch     = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                StSearch: begin
                    prev_d       = bus.data_in;
                    hist_valid_d = 1'b1;
                    if (!hist_valid_q) begin
                        good_run_d = '0;
                    end else if (bus.data_in == prev_inc) begin
                        // good_run_q < LOCK_COUNT here, so good_inc cannot overflow.
                        if (good_inc == GOOD_LOCK) begin
                            state_d    = StLocked;
                            expected_d = sample_inc;
                            err_run_d  = '0;
                            good_run_d = '0;
                        end else begin
                            good_run_d = good_inc;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
                StLocked: begin
                    // Flywheel: expectation advances whether or not the word matched.
                    expected_d = expected_q + 1'b1;
                    if (bus.data_in == expected_q) begin
                        err_run_d = '0;
                    end else begin
                        mismatch = 1'b1;
                        error_d  = 1'b1;
                        if (err_inc == ERR_UNLOCK) begin
                            state_d    = StSearch;
                            good_run_d = '0;
                            prev_d     = bus.data_in;
                            err_run_d  = '0;
                        end else begin
                            err_run_d = err_inc;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    // A mismatch in the same cycle as a clear still counts as one error.
    always_comb begin
        err_count_d = err_count_q;
        if (mismatch) begin
            if (bus.clr_cnt) begin
                err_count_d = CNT_ONE;
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end else if (bus.clr_cnt) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StSearch;
            prev_q       <= '0;
            expected_q   <= '0;
            hist_valid_q <= 1'b0;
            good_run_q   <= '0;
            err_run_q    <= '0;
            error_q      <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            expected_q   <= expected_d;
            hist_valid_q <= hist_valid_d;
            good_run_q   <= good_run_d;
            err_run_q    <= err_run_d;
            error_q      <= error_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.locked    = (state_q == StLocked);
    assign bus.error     = error_q;
    assign bus.err_count = err_count_q;

`ifdef SEQ_CHECK_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_q | mismatch;
        end
    end

    assign bus.err_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: default instance plus a 2-bit-counter instance for saturation.
module tb_seq_checker;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    seq_checker_if #(.DATA_WIDTH(4), .ERR_CNT_WIDTH(8)) a_if ();
    seq_checker_if #(.DATA_WIDTH(4), .ERR_CNT_WIDTH(2)) b_if ();

    seq_checker #(
        .DATA_WIDTH    (4),
        .LOCK_COUNT    (3),
        .UNLOCK_ERRORS (2),
        .ERR_CNT_WIDTH (8)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    seq_checker #(
        .DATA_WIDTH    (4),
        .LOCK_COUNT    (3),
        .UNLOCK_ERRORS (8),
        .ERR_CNT_WIDTH (2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic [3:0] d, input logic v, input logic c);
        a_if.data_in  = d;
        a_if.in_valid = v;
        a_if.clr_cnt  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [3:0] d, input logic v, input logic c);
        b_if.data_in  = d;
        b_if.in_valid = v;
        b_if.clr_cnt  = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] d_lock [4];
        logic       l_lock [4];
        logic [3:0] d_glt  [5];
        logic       e_glt  [5];
        logic [3:0] d_unl  [4];
        logic       e_unl  [4];
        logic       l_unl  [4];
        logic [3:0] d_rel  [4];
        logic       l_rel  [4];
        logic [1:0] c_sat  [5];

        d_lock = '{4'h0, 4'h1, 4'h2, 4'h3};
        l_lock = '{1'b0, 1'b0, 1'b0, 1'b1};
        d_glt  = '{4'h5, 4'h6, 4'h9, 4'h8, 4'h9};
        e_glt  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        d_unl  = '{4'h5, 4'h6, 4'hA, 4'hA};
        e_unl  = '{1'b0, 1'b0, 1'b1, 1'b1};
        l_unl  = '{1'b1, 1'b1, 1'b1, 1'b0};
        d_rel  = '{4'h3, 4'h4, 4'h5, 4'h6};
        l_rel  = '{1'b0, 1'b0, 1'b0, 1'b1};
        c_sat  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        a_if.data_in = '0; a_if.in_valid = 1'b0; a_if.clr_cnt = 1'b0;
        b_if.data_in = '0; b_if.in_valid = 1'b0; b_if.clr_cnt = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_locked", a_if.locked, 0);
        check_eq("rst_count", a_if.err_count, 0);
        check_eq("rst_error", a_if.error, 0);
        reset = 1'b1;

        // Lock on 0,1,2,3
        for (int i = 0; i < 4; i++) begin
            step_a(d_lock[i], 1'b1, 1'b0);
            check_eq($sformatf("lock_locked_%0d", i), a_if.locked, l_lock[i]);
            check_eq($sformatf("lock_error_%0d", i), a_if.error, 0);
        end

        // Run up to wrap, then D,E,F,0,1
        for (int i = 4; i < 13; i++) step_a(4'(i), 1'b1, 1'b0);
        for (int i = 13; i < 18; i++) begin
            step_a(4'(i), 1'b1, 1'b0);
            check_eq($sformatf("wrap_error_%0d", i), a_if.error, 0);
            check_eq($sformatf("wrap_locked_%0d", i), a_if.locked, 1);
        end
        check_eq("wrap_count", a_if.err_count, 0);

        // Glitch: 2,3,4 then 5,6,9,8,9
        for (int i = 2; i < 5; i++) step_a(4'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step_a(d_glt[i], 1'b1, 1'b0);
            check_eq($sformatf("glitch_error_%0d", i), a_if.error, e_glt[i]);
            check_eq($sformatf("glitch_locked_%0d", i), a_if.locked, 1);
        end
        check_eq("glitch_count", a_if.err_count, 1);

        // Clear with no sample: count drops, lock and expectation (A) hold
        step_a(4'h0, 1'b0, 1'b1);
        check_eq("clr_count", a_if.err_count, 0);
        check_eq("clr_locked", a_if.locked, 1);

        // Flywheel A..F,0..4 then 5,6,A,A
        for (int i = 10; i < 21; i++) step_a(4'(i), 1'b1, 1'b0);
        check_eq("fly_error", a_if.error, 0);
        for (int i = 0; i < 4; i++) begin
            step_a(d_unl[i], 1'b1, 1'b0);
            check_eq($sformatf("unlock_error_%0d", i), a_if.error, e_unl[i]);
            check_eq($sformatf("unlock_locked_%0d", i), a_if.locked, l_unl[i]);
        end
        check_eq("unlock_count", a_if.err_count, 2);

        // Relock on 3,4,5,6 (3 does not follow A)
        for (int i = 0; i < 4; i++) begin
            step_a(d_rel[i], 1'b1, 1'b0);
            check_eq($sformatf("relock_locked_%0d", i), a_if.locked, l_rel[i]);
            check_eq($sformatf("relock_error_%0d", i), a_if.error, 0);
        end

        // Gaps with garbage data must not disturb state
        for (int i = 0; i < 3; i++) begin
            step_a(4'hC, 1'b0, 1'b0);
            check_eq($sformatf("gap_locked_%0d", i), a_if.locked, 1);
            check_eq($sformatf("gap_error_%0d", i), a_if.error, 0);
        end
        step_a(4'h7, 1'b1, 1'b0);
        check_eq("gap_resume_error", a_if.error, 0);
        check_eq("gap_resume_count", a_if.err_count, 2);
`ifdef SEQ_CHECK_STICKY_EN
        check_eq("sticky_set", a_if.err_sticky, 1);
`endif

        // Reset while locked
        reset = 1'b0;
        step_a(4'h8, 1'b1, 1'b0);
        reset = 1'b1;
        check_eq("mid_rst_locked", a_if.locked, 0);
        check_eq("mid_rst_count", a_if.err_count, 0);
`ifdef SEQ_CHECK_STICKY_EN
        check_eq("sticky_rst", a_if.err_sticky, 0);
`endif
        step_a(4'h9, 1'b1, 1'b0);
        check_eq("post_rst_locked", a_if.locked, 0);
        a_if.in_valid = 1'b0;

        // Saturation instance: lock, then five wrong words
        for (int i = 0; i < 4; i++) step_b(4'(i), 1'b1, 1'b0);
        check_eq("sat_lock", b_if.locked, 1);
        for (int i = 0; i < 5; i++) begin
            step_b(4'h0, 1'b1, 1'b0);
            check_eq($sformatf("sat_count_%0d", i), b_if.err_count, c_sat[i]);
            check_eq($sformatf("sat_error_%0d", i), b_if.error, 1);
        end
        check_eq("sat_locked", b_if.locked, 1);
        step_b(4'h0, 1'b1, 1'b1);
        check_eq("clr_mis_count", b_if.err_count, 1);
        check_eq("clr_mis_error", b_if.error, 1);
        check_eq("clr_mis_locked", b_if.locked, 1);
        step_b(4'h0, 1'b0, 1'b1);
        check_eq("clr_only_count", b_if.err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
